imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream made of a 32-bit big-endian word count
// followed by big-endian data words, and writes each word to consecutive addresses
// starting at BASE_ADDR. The CPU is held until the load completes.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte
// and the err_checksum port.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        write_enabled,
    output logic [31:0] input_address,
    output logic [31:0] input_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err_length
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic        err_checksum
`endif
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StLen, StData, StWrite, StCksum, StDone
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StLen, StData, StWrite, StDone
    } state_e;
`endif

    state_e      state_q, state_d;
    state_e      final_st;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic        err_length_q, err_length_d;
    logic        byte_fire;
    logic [31:0] len_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
    logic        err_checksum_q, err_checksum_d;
`endif

    // State-decoded outputs
    always_comb begin
        byte_ready    = (state_q == StLen) || (state_q == StData);
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready    = byte_ready || (state_q == StCksum);
        final_st      = StCksum;
`else
        final_st      = StDone;
`endif
        write_enabled = (state_q == StWrite);
        cpu_hold      = (state_q != StDone);
        done          = (state_q == StDone);
        byte_fire     = byte_valid && byte_ready;
        len_next      = {cnt_q[23:0], byte_data};
    end

    assign input_address = addr_q;
    assign input_data    = data_q;
    assign err_length    = err_length_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err_checksum  = err_checksum_q;
`endif

    // Next-state logic: header/word assembly, write sequencing, error flags
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        addr_d       = addr_q;
        err_length_d = err_length_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d          = xor_q;
        err_checksum_d = err_checksum_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StLen;
                    byte_cnt_d   = 2'd0;
                    cnt_d        = 32'd0;
                    addr_d       = BASE_ADDR;
                    err_length_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d          = 8'd0;
                    err_checksum_d = 1'b0;
`endif
                end
            end
            StLen: begin
                if (byte_fire) begin
                    cnt_d      = len_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_next == 32'd0) begin
                            state_d = final_st;
                        end else if (len_next > 32'(MAX_WORDS)) begin
                            err_length_d = 1'b1;
                            state_d      = StDone;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (byte_fire) begin
                    data_d     = {data_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d      = xor_q ^ byte_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d = addr_q + 32'd4;
                cnt_d  = cnt_q - 32'd1;
                state_d = (cnt_q == 32'd1) ? final_st : StData;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCksum: begin
                if (byte_fire) begin
                    err_checksum_d = (byte_data != xor_q);
                    state_d        = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            byte_cnt_q   <= 2'd0;
            cnt_q        <= 32'd0;
            data_q       <= 32'd0;
            addr_q       <= BASE_ADDR;
            err_length_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q          <= 8'd0;
            err_checksum_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            err_length_q <= err_length_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q          <= xor_d;
            err_checksum_q <= err_checksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader; a negedge monitor logs every write strobe.
module tb_imem_loader;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        write_enabled;
    logic [31:0] input_address;
    logic [31:0] input_data;
    logic        cpu_hold;
    logic        done;
    logic        err_length;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        err_checksum;
`endif

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    int base_n;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    imem_loader dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .write_enabled(write_enabled),
        .input_address(input_address),
        .input_data   (input_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err_length   (err_length)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .err_checksum (err_checksum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Log writes away from the active edge
    always @(negedge clock) begin
        if (write_enabled && n_wr < 64) begin
            wr_addr[n_wr] = input_address;
            wr_data[n_wr] = input_data;
            n_wr = n_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until the handshake edge has passed
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'(byte_ready), 32'd1);
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        int g = int'($urandom_range(0, 3));
        for (int i = 0; i < g; i++) @(negedge clock);
        send_byte(b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"}, 32'(write_enabled), 32'd0);
        check({tag, "_addr"}, input_address, 32'h0);
        check({tag, "_data"}, input_data, 32'h0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_errlen"}, 32'(err_length), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check({tag, "_errck"}, 32'(err_checksum), 32'd0);
`endif
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_ready", 32'(byte_ready), 32'd0);

        // Two-word load
        pulse_start();
        check("len_ready", 32'(byte_ready), 32'd1);
        check("len_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        // One cycle after the 4th byte is accepted, the write strobe is up
        check("lat_we", 32'(write_enabled), 32'd1);
        check("lat_addr", input_address, 32'h0);
        check("lat_data", input_data, 32'h1234_5678);
        check("write_ready", 32'(byte_ready), 32'd0);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_done();
        @(negedge clock);
        check("l1_count", 32'(n_wr), 32'd2);
        check("l1_a0", wr_addr[0], 32'h0);
        check("l1_d0", wr_data[0], 32'h1234_5678);
        check("l1_a1", wr_addr[1], 32'h4);
        check("l1_d1", wr_data[1], 32'h9ABC_DEF0);
        check("l1_hold", 32'(cpu_hold), 32'd0);
        check("l1_errlen", 32'(err_length), 32'd0);
        check("l1_ready", 32'(byte_ready), 32'd0);

        // Zero-length image
        base_n = n_wr;
        pulse_start();
        check("z_done_clr", 32'(done), 32'd0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check("z_done", 32'(done), 32'd1);
        @(negedge clock);
        check("z_count", 32'(n_wr), 32'(base_n));

        // Length one above the limit
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
        check("ovr_errlen", 32'(err_length), 32'd1);
        check("ovr_done", 32'(done), 32'd1);
        @(negedge clock);
        check("ovr_count", 32'(n_wr), 32'(base_n));

        // Length exactly at the limit is accepted; start clears err_length
        pulse_start();
        check("max_errclr", 32'(err_length), 32'd0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        check("max_ready", 32'(byte_ready), 32'd1);
        check("max_done", 32'(done), 32'd0);
        check("max_errlen", 32'(err_length), 32'd0);

        // Abort mid-word with reset
        send_byte(8'hAA); send_byte(8'hBB);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clock);
        check("abort_count", 32'(n_wr), 32'(base_n));
        reset_n = 1'b1;
        @(negedge clock);

        // Full load with random byte gaps and a start pulse during DATA
        pulse_start();
        send_gap(8'h00); send_gap(8'h00); send_gap(8'h00); send_gap(8'h02);
        send_gap(8'h12); send_gap(8'h34);
        pulse_start();
        send_gap(8'h56); send_gap(8'h78);
        send_gap(8'h9A); send_gap(8'hBC); send_gap(8'hDE); send_gap(8'hF0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_gap(8'h00);
`endif
        wait_done();
        @(negedge clock);
        check("g_count", 32'(n_wr), 32'(base_n + 2));
        check("g_a0", wr_addr[base_n], 32'h0);
        check("g_d0", wr_data[base_n], 32'h1234_5678);
        check("g_a1", wr_addr[base_n + 1], 32'h4);
        check("g_d1", wr_data[base_n + 1], 32'h9ABC_DEF0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h44);
        check("ck_ok_done", 32'(done), 32'd1);
        check("ck_ok_err", 32'(err_checksum), 32'd0);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h45);
        check("ck_bad_done", 32'(done), 32'd1);
        check("ck_bad_err", 32'(err_checksum), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
